// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the shared external memory port.
// The arbiter uses the master view; caches and memory together form the slave view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_rvalid;
    logic                  i_done;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_wdata_ready;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_rvalid;
    logic                  d_done;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wdata_valid;
    logic                  mem_wdata_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rdata_valid;

    modport master (
        input  i_req, i_addr,
        output i_rdata, i_rvalid, i_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_wdata_ready, d_rdata, d_rvalid, d_done,
        output mem_req_valid, mem_req_we, mem_req_addr,
        input  mem_req_ready,
        output mem_wdata, mem_wdata_valid,
        input  mem_wdata_ready, mem_rdata, mem_rdata_valid
    );

    modport slave (
        output i_req, i_addr,
        input  i_rdata, i_rvalid, i_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_wdata_ready, d_rdata, d_rvalid, d_done,
        input  mem_req_valid, mem_req_we, mem_req_addr,
        output mem_req_ready,
        input  mem_wdata, mem_wdata_valid,
        output mem_wdata_ready, mem_rdata, mem_rdata_valid
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-cache refills and D-cache refills/writebacks.
// D side wins arbitration; an aging counter forces an I grant after MAX_I_WAIT D grants.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no burst; arbitrate between i_req and d_req
//   ST_ADDR  | address phase: mem_req_valid high until mem_req_ready
//   ST_RDATA | forwarding LINE_WORDS read beats to the owner
//   ST_WDATA | streaming LINE_WORDS D-cache writeback beats to memory
//   ST_DONE  | one-cycle done pulse to the owner, then back to idle
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int MAX_I_WAIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int WAIT_W = (MAX_I_WAIT < 1) ? 1 : $clog2(MAX_I_WAIT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_I_WAIT);

    if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line_words
        $error("mem_port_arbiter: LINE_WORDS must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t                state;
    owner_t                owner;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [WAIT_W-1:0]     wait_cnt;

    logic                  req_valid_q;
    logic                  req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic                  wdata_valid_q;
    logic                  i_done_q;
    logic                  d_done_q;

    logic                  grant_i;
    logic                  grant_d;
    logic [DATA_WIDTH-1:0] rdata_fwd;

    // I only wins a contested slot once it has watched MAX_I_WAIT D grants go by.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (bus.d_req && !(bus.i_req && (wait_cnt == WAIT_MAX))) begin
            grant_d = 1'b1;
        end else if (bus.i_req) begin
            grant_i = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            owner         <= OWN_D;
            beat_cnt      <= '0;
            wait_cnt      <= '0;
            req_valid_q   <= 1'b0;
            req_we_q      <= 1'b0;
            req_addr_q    <= '0;
            wdata_valid_q <= 1'b0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        state       <= ST_ADDR;
                        owner       <= OWN_D;
                        req_valid_q <= 1'b1;
                        req_we_q    <= bus.d_we;
                        req_addr_q  <= bus.d_addr;
                        if (bus.i_req && (wait_cnt != WAIT_MAX)) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else if (grant_i) begin
                        state       <= ST_ADDR;
                        owner       <= OWN_I;
                        req_valid_q <= 1'b1;
                        req_we_q    <= 1'b0;
                        req_addr_q  <= bus.i_addr;
                        wait_cnt    <= '0;
                    end
                end

                ST_ADDR: begin
                    if (bus.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        beat_cnt    <= '0;
                        if (req_we_q) begin
                            state         <= ST_WDATA;
                            wdata_valid_q <= 1'b1;
                        end else begin
                            state <= ST_RDATA;
                        end
                    end
                end

                ST_RDATA: begin
                    if (bus.mem_rdata_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= ST_DONE;
                            if (owner == OWN_I) begin
                                i_done_q <= 1'b1;
                            end else begin
                                d_done_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_WDATA: begin
                    if (bus.mem_wdata_ready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state         <= ST_DONE;
                            wdata_valid_q <= 1'b0;
                            d_done_q      <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    i_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read beats pass straight through; only the owner sees rvalid.
    assign rdata_fwd         = bus.mem_rdata;
    assign bus.i_rdata       = rdata_fwd;
    assign bus.d_rdata       = rdata_fwd;
    assign bus.i_rvalid      = (state == ST_RDATA) && (owner == OWN_I) && bus.mem_rdata_valid;
    assign bus.d_rvalid      = (state == ST_RDATA) && (owner == OWN_D) && bus.mem_rdata_valid;
    assign bus.i_done        = i_done_q;
    assign bus.d_done        = d_done_q;

    assign bus.mem_req_valid   = req_valid_q;
    assign bus.mem_req_we      = req_we_q;
    assign bus.mem_req_addr    = req_addr_q;
    assign bus.mem_wdata       = bus.d_wdata;
    assign bus.mem_wdata_valid = wdata_valid_q;
    assign bus.d_wdata_ready   = wdata_valid_q && bus.mem_wdata_ready;

    a_rvalid_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.i_rvalid && bus.d_rvalid));
    a_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.i_done && bus.d_done));
    a_phase_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.mem_req_valid && bus.mem_wdata_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checked every cycle
// plus literal expectations for each scenario.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int MW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LINE_WORDS(LW),
        .MAX_I_WAIT(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: one burst record plus an aging streak.
    bit               m_active, m_addr_wait, m_owner_i, m_we, m_done_now, m_done_i;
    logic [AW-1:0]    m_addr;
    int               m_beats_left, m_streak;

    initial begin
        m_active = 0; m_addr_wait = 0; m_owner_i = 0; m_we = 0;
        m_done_now = 0; m_done_i = 0; m_addr = '0; m_beats_left = 0; m_streak = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active = 0; m_addr_wait = 0; m_done_now = 0; m_beats_left = 0; m_streak = 0;
            end else if (m_done_now) begin
                m_done_now = 0;
            end else if (!m_active) begin
                if (bus.d_req && !(bus.i_req && m_streak >= MW)) begin
                    m_active = 1; m_addr_wait = 1; m_owner_i = 0;
                    m_we = bus.d_we; m_addr = bus.d_addr;
                    if (bus.i_req) m_streak = (m_streak < MW) ? m_streak + 1 : MW;
                end else if (bus.i_req) begin
                    m_active = 1; m_addr_wait = 1; m_owner_i = 1;
                    m_we = 0; m_addr = bus.i_addr;
                    m_streak = 0;
                end
            end else if (m_addr_wait) begin
                if (bus.mem_req_ready) begin
                    m_addr_wait = 0;
                    m_beats_left = LW;
                end
            end else if (m_we ? bus.mem_wdata_ready : bus.mem_rdata_valid) begin
                m_beats_left--;
                if (m_beats_left == 0) begin
                    m_active = 0; m_done_now = 1; m_done_i = m_owner_i;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        bit e_req, e_data, e_ir, e_dr;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_req  = m_active && m_addr_wait;
                e_data = m_active && !m_addr_wait;
                e_ir   = e_data && !m_we && m_owner_i && bus.mem_rdata_valid;
                e_dr   = e_data && !m_we && !m_owner_i && bus.mem_rdata_valid;
                chk("mem_req_valid", bus.mem_req_valid, e_req);
                if (e_req) begin
                    chk("mem_req_addr", bus.mem_req_addr, m_addr);
                    chk("mem_req_we", bus.mem_req_we, m_we);
                end
                chk("mem_wdata_valid", bus.mem_wdata_valid, e_data && m_we);
                chk("d_wdata_ready", bus.d_wdata_ready, e_data && m_we && bus.mem_wdata_ready);
                if (e_data && m_we) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
                chk("i_rvalid", bus.i_rvalid, e_ir);
                chk("d_rvalid", bus.d_rvalid, e_dr);
                if (e_ir) chk("i_rdata", bus.i_rdata, bus.mem_rdata);
                if (e_dr) chk("d_rdata", bus.d_rdata, bus.mem_rdata);
                chk("i_done", bus.i_done, m_done_now && m_done_i);
                chk("d_done", bus.d_done, m_done_now && !m_done_i);
            end
        end
    end

    // Observation log of what the DUT actually did, for the literal checks.
    logic [31:0] q_i[$], q_d[$], q_wd[$], q_grant[$];
    int n_idone, n_ddone, n_wrdy;
    initial begin
        bit prev_req = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (bus.i_rvalid) q_i.push_back(bus.i_rdata);
                if (bus.d_rvalid) q_d.push_back(bus.d_rdata);
                if (bus.i_done) n_idone++;
                if (bus.d_done) n_ddone++;
                if (bus.d_wdata_ready) begin
                    n_wrdy++;
                    q_wd.push_back(bus.mem_wdata);
                end
                if (bus.mem_req_valid && !prev_req) q_grant.push_back(bus.mem_req_addr);
                prev_req = bus.mem_req_valid;
            end
        end
    end

    task automatic clear_logs();
        q_i.delete(); q_d.delete(); q_wd.delete(); q_grant.delete();
        n_idone = 0; n_ddone = 0; n_wrdy = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_valid(input string tag);
        int n = 0;
        while (!bus.mem_req_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_wait_req_valid"}, bus.mem_req_valid, 1'b1);
    endtask

    // Call in the address-phase cycle; returns in the cycle after the last beat.
    task automatic serve_read(input logic [31:0] base);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < LW; k++) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata = base + 32'(k);
            tick();
        end
        bus.mem_rdata_valid = 1'b0;
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
        chk({tag, "_mem_wdata_valid"}, bus.mem_wdata_valid, 1'b0);
        chk({tag, "_d_wdata_ready"}, bus.d_wdata_ready, 1'b0);
        chk({tag, "_i_rvalid"}, bus.i_rvalid, 1'b0);
        chk({tag, "_d_rvalid"}, bus.d_rvalid, 1'b0);
        chk({tag, "_i_done"}, bus.i_done, 1'b0);
        chk({tag, "_d_done"}, bus.d_done, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1_beats [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        logic [31:0] wv [4]       = '{32'hD0D0_0000, 32'hD0D0_1111, 32'hD0D0_2222, 32'hD0D0_3333};
        logic        pat [6]      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_grant [8] = '{32'h400, 32'h400, 32'h400, 32'h300,
                                       32'h400, 32'h400, 32'h400, 32'h300};
        bit rdy;
        int k;

        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_req_ready = 0; bus.mem_wdata_ready = 0;
        bus.mem_rdata = '0; bus.mem_rdata_valid = 0;
        clear_logs();

        // Reset state
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        quiet("reset");
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        quiet("idle_no_req");

        // Lone I read @0x100
        tick();
        clear_logs();
        bus.i_addr = 32'h100;
        bus.i_req = 1'b1;
        wait_req_valid("t1");
        chk("t1_addr", bus.mem_req_addr, 32'h100);
        chk("t1_we", bus.mem_req_we, 1'b0);
        serve_read(32'hA0);
        chk("t1_done_latency", bus.i_done, 1'b1);
        bus.i_req = 1'b0;
        tick();
        tick();
        chk("t1_nbeats", q_i.size(), 4);
        for (int b = 0; b < 4; b++) if (b < q_i.size()) chk("t1_beat", q_i[b], t1_beats[b]);
        chk("t1_d_beats", q_d.size(), 0);
        chk("t1_idone_cnt", n_idone, 1);
        chk("t1_ddone_cnt", n_ddone, 0);

        // D writeback @0x200 with stalling memory
        clear_logs();
        bus.d_we = 1'b1;
        bus.d_addr = 32'h200;
        bus.d_wdata = wv[0];
        bus.d_req = 1'b1;
        wait_req_valid("t2");
        chk("t2_addr", bus.mem_req_addr, 32'h200);
        chk("t2_we", bus.mem_req_we, 1'b1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        k = 0;
        for (int j = 0; j < 6; j++) begin
            bus.mem_wdata_ready = pat[j];
            @(negedge clk);
            rdy = bus.d_wdata_ready;
            tick();
            if (rdy && k < LW - 1) k++;
            bus.d_wdata = wv[k];
        end
        bus.mem_wdata_ready = 1'b0;
        chk("t2_done_latency", bus.d_done, 1'b1);
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        tick();
        tick();
        chk("t2_wrdy_cnt", n_wrdy, 4);
        for (int b = 0; b < 4; b++) if (b < q_wd.size()) chk("t2_wbeat", q_wd[b], wv[b]);
        chk("t2_ddone_cnt", n_ddone, 1);

        // Both requesting continuously: aging forces every fourth grant to I
        clear_logs();
        bus.i_addr = 32'h300;
        bus.d_addr = 32'h400;
        bus.d_we = 1'b0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int b = 0; b < 8; b++) begin
            wait_req_valid("t3");
            serve_read(32'h3000 + 32'(b * 16));
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        tick();
        chk("t3_grant_cnt", q_grant.size(), 8);
        for (int b = 0; b < 8; b++) if (b < q_grant.size()) chk("t3_grant_seq", q_grant[b], exp_grant[b]);
        chk("t3_idone_cnt", n_idone, 2);
        chk("t3_ddone_cnt", n_ddone, 6);

        // Address phase stalled 5 cycles
        clear_logs();
        bus.d_addr = 32'h500;
        bus.d_we = 1'b0;
        bus.d_req = 1'b1;
        wait_req_valid("t4");
        for (int c = 0; c < 5; c++) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata = 32'hBAD0 + 32'(c);
            @(negedge clk);
            chk("t4_valid_held", bus.mem_req_valid, 1'b1);
            chk("t4_addr_held", bus.mem_req_addr, 32'h500);
            chk("t4_we_held", bus.mem_req_we, 1'b0);
            chk("t4_no_beat", bus.d_rvalid, 1'b0);
            tick();
        end
        bus.mem_rdata_valid = 1'b0;
        serve_read(32'h5000);
        chk("t4_done", bus.d_done, 1'b1);
        bus.d_req = 1'b0;
        tick();
        tick();
        chk("t4_grant_cnt", q_grant.size(), 1);
        chk("t4_beat_cnt", q_d.size(), 4);

        // Reset during third read beat, D pending
        clear_logs();
        bus.i_addr = 32'h600;
        bus.i_req = 1'b1;
        wait_req_valid("t5");
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.d_addr = 32'h700;
        bus.d_we = 1'b0;
        bus.d_req = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata = 32'h6000 + 32'(b);
            tick();
        end
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata = 32'h6002;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_req = 1'b0;
        bus.mem_rdata = 32'h6003;
        @(negedge clk);
        quiet("t5_after_rst");
        tick();
        bus.mem_rdata_valid = 1'b0;
        wait_req_valid("t5");
        chk("t5_d_addr", bus.mem_req_addr, 32'h700);
        serve_read(32'h7000);
        chk("t5_d_done", bus.d_done, 1'b1);
        bus.d_req = 1'b0;
        tick();
        tick();
        chk("t5_idone_cnt", n_idone, 0);

        // d_req rises in the i_done cycle
        clear_logs();
        bus.i_addr = 32'h800;
        bus.i_req = 1'b1;
        wait_req_valid("t6");
        serve_read(32'h8000);
        chk("t6_i_done", bus.i_done, 1'b1);
        bus.i_req = 1'b0;
        bus.d_addr = 32'h900;
        bus.d_we = 1'b0;
        bus.d_req = 1'b1;
        tick();
        chk("t6_idle_gap", bus.mem_req_valid, 1'b0);
        chk("t6_done_once", bus.i_done, 1'b0);
        tick();
        chk("t6_d_granted", bus.mem_req_valid, 1'b1);
        chk("t6_d_addr", bus.mem_req_addr, 32'h900);
        wait_req_valid("t6b");
        serve_read(32'h9000);
        chk("t6_d_done", bus.d_done, 1'b1);
        bus.d_req = 1'b0;
        tick();
        tick();
        chk("t6_idone_cnt", n_idone, 1);
        chk("t6_ddone_cnt", n_ddone, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
